// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch program counter, keeps exactly one
// instruction read in flight, buffers returned words in a small queue and
// hands the queue head to the controller as a decoded instruction register.
module instruction_fetch_unit #(
    parameter int                       ADDRESS_WIDTH = 16,
    parameter int                       QUEUE_DEPTH   = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_ADDRESS = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic                     memory_read_request,
    input  logic                     memory_read_valid,
    input  logic [15:0]              memory_read_data,
    input  logic                     instruction_write_enable,
    output logic                     instruction_ready,
    input  logic                     redirect_enable,
    input  logic [ADDRESS_WIDTH-1:0] redirect_address,
    output logic [3:0]               instruction_operation,
    output logic [3:0]               instruction_destination,
    output logic [3:0]               instruction_operation_extra,
    output logic [3:0]               instruction_source,
    output logic [7:0]               instruction_immediate,
    output logic [ADDRESS_WIDTH-1:0] program_counter
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_REQUEST,
        STATE_WAIT,
        STATE_DROP
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetchPc_q, fetchPc_d;
    logic [15:0]              queueData_q [QUEUE_DEPTH];
    logic [ADDRESS_WIDTH-1:0] queueAddr_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]         writePtr_q;
    logic [PTR_W-1:0]         readPtr_q;
    logic [CNT_W-1:0]         count_q;
    logic [CNT_W-1:0]         countAfter;
    logic [15:0]              instr_q;
    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic                     pushEn;
    logic                     popEn;

    // Push only a response that belongs to the live request; pop only a
    // present head, and never while a redirect is throwing the queue away.
    always_comb begin
        pushEn     = (state_q == STATE_WAIT) && memory_read_valid && !redirect_enable;
        popEn      = instruction_write_enable && (count_q != '0) && !redirect_enable;
        countAfter = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
    end

    // Next fetch address: a redirect wins, otherwise advance past each word
    // that actually lands in the queue (wrapping naturally at the top).
    always_comb begin
        fetchPc_d = fetchPc_q;
        if (redirect_enable) begin
            fetchPc_d = redirect_address;
        end else if (pushEn) begin
            fetchPc_d = fetchPc_q + ADDRESS_WIDTH'(1);
        end
    end

    // Next-state logic; DROP swallows the response of a read that a
    // redirect made stale so that only one read is ever outstanding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE: begin
                if (redirect_enable || (count_q < FULL_COUNT)) begin
                    state_d = STATE_REQUEST;
                end
            end
            STATE_REQUEST: begin
                state_d = redirect_enable ? STATE_DROP : STATE_WAIT;
            end
            STATE_WAIT: begin
                if (redirect_enable) begin
                    state_d = memory_read_valid ? STATE_REQUEST : STATE_DROP;
                end else if (memory_read_valid) begin
                    state_d = (countAfter < FULL_COUNT) ? STATE_REQUEST : STATE_IDLE;
                end
            end
            STATE_DROP: begin
                if (memory_read_valid) begin
                    state_d = STATE_REQUEST;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // State and fetch counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= STATE_IDLE;
            fetchPc_q <= RESET_ADDRESS;
        end else begin
            state_q   <= state_d;
            fetchPc_q <= fetchPc_d;
        end
    end

    // Circular instruction queue holding {word, address}; a redirect empties it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queueData_q[i] <= '0;
                queueAddr_q[i] <= '0;
            end
            writePtr_q <= '0;
            readPtr_q  <= '0;
            count_q    <= '0;
        end else if (redirect_enable) begin
            writePtr_q <= '0;
            readPtr_q  <= '0;
            count_q    <= '0;
        end else begin
            if (pushEn) begin
                queueData_q[writePtr_q] <= memory_read_data;
                queueAddr_q[writePtr_q] <= fetchPc_q;
                writePtr_q              <= writePtr_q + PTR_W'(1);
            end
            if (popEn) begin
                readPtr_q <= readPtr_q + PTR_W'(1);
            end
            count_q <= countAfter;
        end
    end

    // Instruction register and its address, loaded from the head on a fetch strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (popEn) begin
            instr_q <= queueData_q[readPtr_q];
            pc_q    <= queueAddr_q[readPtr_q];
        end
    end

    // Memory interface, queue status and decoded instruction fields.
    always_comb begin
        memory_read_request         = (state_q == STATE_REQUEST);
        memory_address              = fetchPc_q;
        instruction_ready           = (count_q != '0);
        instruction_operation       = instr_q[15:12];
        instruction_destination     = instr_q[11:8];
        instruction_operation_extra = instr_q[7:4];
        instruction_source          = instr_q[3:0];
        instruction_immediate       = instr_q[7:0];
        program_counter             = pc_q;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit: inputs change and outputs
// are sampled just after the falling edge, the design acts on the rising edge.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] memory_address;
    logic        memory_read_request;
    logic        memory_read_valid;
    logic [15:0] memory_read_data;
    logic        instruction_write_enable;
    logic        instruction_ready;
    logic        redirect_enable;
    logic [15:0] redirect_address;
    logic [3:0]  instruction_operation;
    logic [3:0]  instruction_destination;
    logic [3:0]  instruction_operation_extra;
    logic [3:0]  instruction_source;
    logic [7:0]  instruction_immediate;
    logic [15:0] program_counter;

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit dut (
        .clock                       (clock),
        .reset                       (reset),
        .memory_address              (memory_address),
        .memory_read_request         (memory_read_request),
        .memory_read_valid           (memory_read_valid),
        .memory_read_data            (memory_read_data),
        .instruction_write_enable    (instruction_write_enable),
        .instruction_ready           (instruction_ready),
        .redirect_enable             (redirect_enable),
        .redirect_address            (redirect_address),
        .instruction_operation       (instruction_operation),
        .instruction_destination     (instruction_destination),
        .instruction_operation_extra (instruction_operation_extra),
        .instruction_source          (instruction_source),
        .instruction_immediate       (instruction_immediate),
        .program_counter             (program_counter)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Answer the request seen at the current falling edge: one cycle later
    // drive a single-cycle valid carrying the given word.
    task automatic applyStimulus(input logic [15:0] data);
        @(negedge clock);
        memory_read_valid = 1'b1;
        memory_read_data  = data;
        @(negedge clock);
        memory_read_valid = 1'b0;
    endtask

    // Wait a bounded number of cycles for a read request to appear.
    task automatic waitRequest(input int maxCycles);
        int n = 0;
        while (!memory_read_request && n < maxCycles) begin
            @(negedge clock);
            n++;
        end
        checkOutput("waitRequest", 32'(memory_read_request), 32'd1);
    endtask

    initial begin
        reset                    = 1'b0;
        memory_read_valid        = 1'b0;
        memory_read_data         = '0;
        instruction_write_enable = 1'b0;
        redirect_enable          = 1'b0;
        redirect_address         = '0;
        repeat (2) @(negedge clock);

        // Values held during reset.
        checkOutput("rstReq",   32'(memory_read_request), 32'd0);
        checkOutput("rstAddr",  32'(memory_address),      32'h0);
        checkOutput("rstReady", 32'(instruction_ready),   32'd0);
        checkOutput("rstPc",    32'(program_counter),     32'h0);
        checkOutput("rstImm",   32'(instruction_immediate), 32'h0);

        // First fetch after reset, word 5123 at address 0.
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t1Req",    32'(memory_read_request), 32'd1);
        checkOutput("t1Addr",   32'(memory_address),      32'h0);
        @(negedge clock);
        checkOutput("t1WaitReq", 32'(memory_read_request), 32'd0);
        checkOutput("t1NoBypass", 32'(instruction_ready), 32'd0);
        memory_read_valid = 1'b1;
        memory_read_data  = 16'h5123;
        @(negedge clock);
        memory_read_valid = 1'b0;
        checkOutput("t1Ready",  32'(instruction_ready),   32'd1);
        checkOutput("t1Req2",   32'(memory_read_request), 32'd1);
        checkOutput("t1Addr2",  32'(memory_address),      32'h1);
        instruction_write_enable = 1'b1;
        @(negedge clock);
        instruction_write_enable = 1'b0;
        checkOutput("t1Op",     32'(instruction_operation),       32'h5);
        checkOutput("t1Dst",    32'(instruction_destination),     32'h1);
        checkOutput("t1Ext",    32'(instruction_operation_extra), 32'h2);
        checkOutput("t1Src",    32'(instruction_source),          32'h3);
        checkOutput("t1Imm",    32'(instruction_immediate),       32'h23);
        checkOutput("t1Pc",     32'(program_counter),             32'h0);
        checkOutput("t1Empty",  32'(instruction_ready),           32'd0);

        // Queue fills with two words, then fetching stops until a consume.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("t2Addr0", 32'(memory_address), 32'h0);
        applyStimulus(16'hA000);
        checkOutput("t2Req1",  32'(memory_read_request), 32'd1);
        checkOutput("t2Addr1", 32'(memory_address),      32'h1);
        applyStimulus(16'hA001);
        checkOutput("t2Ready", 32'(instruction_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2IdleReq", 32'(memory_read_request), 32'd0);
            @(negedge clock);
        end
        instruction_write_enable = 1'b1;
        @(negedge clock);
        instruction_write_enable = 1'b0;
        checkOutput("t2Ir",    32'({instruction_operation, instruction_destination,
                                    instruction_immediate}), 32'hA000);
        checkOutput("t2Pc",    32'(program_counter), 32'h0);
        waitRequest(5);
        checkOutput("t2Addr2", 32'(memory_address), 32'h2);

        // Redirect while waiting; the stale response arrives three cycles later.
        @(negedge clock);
        redirect_enable  = 1'b1;
        redirect_address = 16'h0040;
        @(negedge clock);
        redirect_enable = 1'b0;
        checkOutput("t3Flush", 32'(instruction_ready),   32'd0);
        checkOutput("t3Drop0", 32'(memory_read_request), 32'd0);
        @(negedge clock);
        checkOutput("t3Drop1", 32'(memory_read_request), 32'd0);
        @(negedge clock);
        checkOutput("t3Drop2", 32'(memory_read_request), 32'd0);
        memory_read_valid = 1'b1;
        memory_read_data  = 16'hDEAD;
        @(negedge clock);
        memory_read_valid = 1'b0;
        checkOutput("t3Req",   32'(memory_read_request), 32'd1);
        checkOutput("t3Addr",  32'(memory_address),      32'h0040);
        checkOutput("t3Discard", 32'(instruction_ready), 32'd0);
        applyStimulus(16'hA1B2);
        checkOutput("t3Ready", 32'(instruction_ready), 32'd1);
        instruction_write_enable = 1'b1;
        @(negedge clock);
        instruction_write_enable = 1'b0;
        checkOutput("t3Pc",    32'(program_counter),             32'h0040);
        checkOutput("t3Op",    32'(instruction_operation),       32'hA);
        checkOutput("t3Dst",   32'(instruction_destination),     32'h1);
        checkOutput("t3Ext",   32'(instruction_operation_extra), 32'hB);
        checkOutput("t3Src",   32'(instruction_source),          32'h2);

        // Redirect and response in the same waiting cycle.
        memory_read_valid = 1'b1;
        memory_read_data  = 16'hBEEF;
        redirect_enable   = 1'b1;
        redirect_address  = 16'h0100;
        @(negedge clock);
        memory_read_valid = 1'b0;
        redirect_enable   = 1'b0;
        checkOutput("t4Req",   32'(memory_read_request),   32'd1);
        checkOutput("t4Addr",  32'(memory_address),        32'h0100);
        checkOutput("t4Ready", 32'(instruction_ready),     32'd0);
        checkOutput("t4Imm",   32'(instruction_immediate), 32'hB2);

        // Redirect beats a consume with two entries queued.
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        checkOutput("t5Full",  32'(instruction_ready),   32'd1);
        checkOutput("t5Idle",  32'(memory_read_request), 32'd0);
        redirect_enable          = 1'b1;
        redirect_address         = 16'h0200;
        instruction_write_enable = 1'b1;
        @(negedge clock);
        redirect_enable          = 1'b0;
        instruction_write_enable = 1'b0;
        checkOutput("t5Ready", 32'(instruction_ready),     32'd0);
        checkOutput("t5Pc",    32'(program_counter),       32'h0040);
        checkOutput("t5Imm",   32'(instruction_immediate), 32'hB2);
        checkOutput("t5Req",   32'(memory_read_request),   32'd1);
        checkOutput("t5Addr",  32'(memory_address),        32'h0200);

        // Redirect during the request cycle to FFFF, then wrap to 0000.
        redirect_enable  = 1'b1;
        redirect_address = 16'hFFFF;
        @(negedge clock);
        redirect_enable = 1'b0;
        checkOutput("t6Drop",  32'(memory_read_request), 32'd0);
        memory_read_valid = 1'b1;
        memory_read_data  = 16'hCAFE;
        @(negedge clock);
        memory_read_valid = 1'b0;
        checkOutput("t6AddrF", 32'(memory_address), 32'hFFFF);
        checkOutput("t6Empty", 32'(instruction_ready), 32'd0);
        applyStimulus(16'h3333);
        checkOutput("t6Req",   32'(memory_read_request), 32'd1);
        checkOutput("t6Wrap",  32'(memory_address),      32'h0000);
        instruction_write_enable = 1'b1;
        @(negedge clock);
        instruction_write_enable = 1'b0;
        checkOutput("t6Pc",    32'(program_counter),       32'hFFFF);
        checkOutput("t6Op",    32'(instruction_operation), 32'h3);

        // Asynchronous reset in the middle of a wait; a late response is ignored.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arReq",   32'(memory_read_request),   32'd0);
        checkOutput("arAddr",  32'(memory_address),        32'h0);
        checkOutput("arReady", 32'(instruction_ready),     32'd0);
        checkOutput("arPc",    32'(program_counter),       32'h0);
        checkOutput("arOp",    32'(instruction_operation), 32'h0);
        checkOutput("arImm",   32'(instruction_immediate), 32'h0);
        @(negedge clock);
        memory_read_valid = 1'b1;
        memory_read_data  = 16'h7777;
        @(negedge clock);
        memory_read_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("arReq2",  32'(memory_read_request), 32'd1);
        checkOutput("arAddr2", 32'(memory_address),      32'h0);
        checkOutput("arReady2", 32'(instruction_ready),  32'd0);
        @(negedge clock);
        checkOutput("arReady3", 32'(instruction_ready),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
